// File: rtl/rom_pkg.sv
// Shared types and limits for the pipelined instruction ROM.
package rom_pkg;

    localparam int unsigned MAX_READ_LATENCY = 4;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10
    } rom_err_e;

    typedef struct packed {
        logic [31:0] data;
        rom_err_e    err;
    } rom_resp_t;

endpackage

// File: rtl/instr_rom_pipe_if.sv
// Fetch request / response handshake between the IF stage and the instruction ROM.
interface instr_rom_pipe_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [1:0]            resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/rom_resp_fifo.sv
// Synchronous FIFO of response entries; arbitrary depth, flushed by rst_n.
module rom_resp_fifo
    import rom_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = rom_resp_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  entry_t wdata_i,
    input  logic   pop_i,
    output entry_t rdata_o,
    output logic   full_o,
    output logic   empty_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t           store_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = store_q[rptr_q];

    always_comb begin
        wptr_d = do_push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = do_pop ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is not reset: an empty FIFO never exposes it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_rom_pipe.sv
// Pipelined byte-addressed instruction ROM with registered read and response buffer.
// Optional statistics counters are enabled by defining ROM_STATS_EN.
module instr_rom_pipe
    import rom_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned READ_LATENCY  = 1,
    parameter bit          BIG_ENDIAN    = 1'b1,
    parameter string       MEM_INIT_FILE = "Temp.hex"
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_rom_pipe_if.slave     bus
`ifdef ROM_STATS_EN
    ,
    output logic [31:0]         stat_fetches,
    output logic [31:0]         stat_errors
`endif
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = READ_LATENCY + 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("READ_LATENCY must be within 1..MAX_READ_LATENCY");
    end

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        rom_err_e              err;
    } resp_t;

    logic [7:0] rom_mem [2**ADDR_WIDTH];

    logic                    accept, pop;
    logic [ADDR_WIDTH:0]     last_addr;
    rom_err_e                req_err;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [CNT_W-1:0]        count_q, count_d;
    resp_t                   pipe_q [READ_LATENCY];
    resp_t                   pipe_d [READ_LATENCY];
    logic [READ_LATENCY-1:0] pvld_q, pvld_d;
    resp_t                   exit_ent, head, fifo_rdata;
    logic                    exit_vld, fifo_push, fifo_pop, fifo_full, fifo_empty;

    // Ready depends on registered occupancy only; resp_ready never reaches it.
    assign bus.req_ready = rst_n && (count_q < CNT_W'(DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        last_addr = {1'b0, bus.req_addr} + (ADDR_WIDTH + 1)'(BYTES - 1);
        if ((bus.req_addr & ADDR_WIDTH'(BYTES - 1)) != '0) begin
            req_err = ERR_MISALIGN;
        end else if (last_addr[ADDR_WIDTH]) begin
            req_err = ERR_RANGE;
        end else begin
            req_err = ERR_NONE;
        end
        rd_word = '0;
        if (accept && req_err == ERR_NONE) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (BIG_ENDIAN) begin
                    rd_word[DATA_WIDTH-1-8*i -: 8] = rom_mem[bus.req_addr + ADDR_WIDTH'(i)];
                end else begin
                    rd_word[8*i +: 8] = rom_mem[bus.req_addr + ADDR_WIDTH'(i)];
                end
            end
        end
    end

    always_comb begin
        pvld_d[0] = accept;
        pipe_d[0] = '{data: rd_word, err: req_err};
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pvld_d[i] = pvld_q[i-1];
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipeline exit falls through to the outputs when the FIFO is empty.
    assign exit_vld       = pvld_q[READ_LATENCY-1];
    assign exit_ent       = pipe_q[READ_LATENCY-1];
    assign head           = fifo_empty ? exit_ent : fifo_rdata;
    assign bus.resp_valid = !fifo_empty || exit_vld;
    assign bus.resp_data  = bus.resp_valid ? head.data : '0;
    assign bus.resp_err   = bus.resp_valid ? head.err : ERR_NONE;
    assign pop            = bus.resp_valid && bus.resp_ready;
    assign fifo_pop       = pop && !fifo_empty;
    assign fifo_push      = exit_vld && !fifo_full && !(fifo_empty && pop);

    always_comb begin
        count_d = count_q;
        if (accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!accept && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            pvld_q  <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            pvld_q  <= pvld_d;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    rom_resp_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (resp_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (exit_ent),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef ROM_STATS_EN
    logic [31:0] fetches_q, fetches_d, errors_q, errors_d;

    always_comb begin
        fetches_d = fetches_q;
        errors_d  = errors_q;
        if (accept && fetches_q != '1) begin
            fetches_d = fetches_q + 32'd1;
        end
        if (accept && req_err != ERR_NONE && errors_q != '1) begin
            errors_d = errors_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetches_q <= '0;
            errors_q  <= '0;
        end else begin
            fetches_q <= fetches_d;
            errors_q  <= errors_d;
        end
    end

    assign stat_fetches = fetches_q;
    assign stat_errors  = errors_q;
`endif

endmodule

// File: tb/tb_instr_rom_pipe.sv
// Randomised bench for instr_rom_pipe: two instances (LAT=1 big-endian, LAT=3 little-endian)
// driven in lockstep and checked against a queue-based transaction model.
module tb_instr_rom_pipe;

    typedef struct {
        int          ready_at;
        logic [31:0] data;
        logic [1:0]  err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [9:0]  req_addr = '0;
    logic        resp_ready = 1'b0;

    logic [7:0]  img [1024];
    exp_t        exp_q [2][$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          acc_cnt [2];
    int          err_cnt [2];

    logic        obs_rdy [2];
    logic        obs_vld [2];
    logic [31:0] obs_dat [2];
    logic [1:0]  obs_err [2];

    always #5 clk = ~clk;

    instr_rom_pipe_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) if_a ();
    instr_rom_pipe_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) if_b ();

    assign if_a.req_valid  = req_valid;
    assign if_a.req_addr   = req_addr;
    assign if_a.resp_ready = resp_ready;
    assign if_b.req_valid  = req_valid;
    assign if_b.req_addr   = req_addr;
    assign if_b.resp_ready = resp_ready;

`ifdef ROM_STATS_EN
    logic [31:0] sf_a, se_a, sf_b, se_b;
`endif

    instr_rom_pipe #(
        .ADDR_WIDTH    (10),
        .DATA_WIDTH    (32),
        .READ_LATENCY  (1),
        .BIG_ENDIAN    (1'b1),
        .MEM_INIT_FILE ("")
    ) u_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (if_a)
`ifdef ROM_STATS_EN
        ,
        .stat_fetches (sf_a),
        .stat_errors  (se_a)
`endif
    );

    instr_rom_pipe #(
        .ADDR_WIDTH    (10),
        .DATA_WIDTH    (32),
        .READ_LATENCY  (3),
        .BIG_ENDIAN    (1'b0),
        .MEM_INIT_FILE ("")
    ) u_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (if_b)
`ifdef ROM_STATS_EN
        ,
        .stat_fetches (sf_b),
        .stat_errors  (se_b)
`endif
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit big_of(input int k);
        return (k == 0);
    endfunction

    // Word as seen by a consumer: bytes taken in address order and shifted into place.
    function automatic exp_t model_fetch(input int addr, input bit big, input int ready_at);
        exp_t e;
        e.ready_at = ready_at;
        e.data     = '0;
        e.err      = 2'b00;
        if (addr % 4 != 0) begin
            e.err = 2'b01;
        end else if (addr + 3 > 1023) begin
            e.err = 2'b10;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (big) e.data = {e.data[23:0], img[addr+i]};
                else     e.data = {img[addr+i], e.data[31:8]};
            end
        end
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic sample();
        obs_rdy[0] = if_a.req_ready;  obs_rdy[1] = if_b.req_ready;
        obs_vld[0] = if_a.resp_valid; obs_vld[1] = if_b.resp_valid;
        obs_dat[0] = if_a.resp_data;  obs_dat[1] = if_b.resp_data;
        obs_err[0] = if_a.resp_err;   obs_err[1] = if_b.resp_err;
    endtask

    // One clock: check outputs against the model, then drive and account for the next edge.
    task automatic cycle(input bit v, input int addr, input bit rr);
        bit ev [2];
        bit er [2];
        @(negedge clk);
        cyc++;
        sample();
        for (int k = 0; k < 2; k++) begin
            ev[k] = (exp_q[k].size() > 0) && (exp_q[k][0].ready_at <= cyc);
            er[k] = (exp_q[k].size() < lat_of(k) + 1);
            check_eq($sformatf("req_ready[%0d]", k), 64'(obs_rdy[k]), 64'(er[k]));
            check_eq($sformatf("resp_valid[%0d]", k), 64'(obs_vld[k]), 64'(ev[k]));
            if (ev[k]) begin
                check_eq($sformatf("resp_data[%0d]", k), 64'(obs_dat[k]), 64'(exp_q[k][0].data));
                check_eq($sformatf("resp_err[%0d]", k), 64'(obs_err[k]), 64'(exp_q[k][0].err));
            end
        end
        req_valid  = v;
        req_addr   = addr[9:0];
        resp_ready = rr;
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            if (ev[k] && rr) void'(exp_q[k].pop_front());
            if (v && er[k]) begin
                e = model_fetch(addr & 1023, big_of(k), cyc + lat_of(k));
                exp_q[k].push_back(e);
                acc_cnt[k]++;
                if (e.err != 2'b00) err_cnt[k]++;
            end
        end
    endtask

    // Reset lands mid-cycle so its effect on the outputs is seen before any clock edge.
    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sample();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst_valid[%0d]", k), 64'(obs_vld[k]), 64'd0);
            check_eq($sformatf("rst_ready[%0d]", k), 64'(obs_rdy[k]), 64'd0);
            check_eq($sformatf("rst_data[%0d]", k), 64'(obs_dat[k]), 64'd0);
            check_eq($sformatf("rst_err[%0d]", k), 64'(obs_err[k]), 64'd0);
            exp_q[k].delete();
            acc_cnt[k] = 0;
            err_cnt[k] = 0;
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, rr);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) img[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) img[i] = 8'((i + 1) * 8'h11);
        for (int i = 0; i < 1024; i++) begin
            u_a.rom_mem[i] = img[i];
            u_b.rom_mem[i] = img[i];
        end
        acc_cnt[0] = 0; acc_cnt[1] = 0;
        err_cnt[0] = 0; err_cnt[1] = 0;

        apply_reset();

        // Back-to-back fetches of the known image prefix.
        cycle(1'b1, 0, 1'b1);
        cycle(1'b1, 4, 1'b1);
        idle(5, 1'b1);

        // Backpressure: ready must drop after DEPTH accepts, then drain in order.
        for (int i = 0; i < 8; i++) cycle(1'b1, 4 * $urandom_range(0, 255), 1'b0);
        idle(3, 1'b0);
        idle(8, 1'b1);

        // Misaligned, last aligned word, misaligned near the top.
        cycle(1'b1, 'h002, 1'b1);
        cycle(1'b1, 'h3FC, 1'b1);
        cycle(1'b1, 'h3FE, 1'b1);
        idle(5, 1'b1);

        // Two responses left buffered when reset hits.
        cycle(1'b1, 'h010, 1'b0);
        cycle(1'b1, 'h014, 1'b0);
        idle(4, 1'b0);
        apply_reset();
        cycle(1'b1, 0, 1'b1);
        idle(5, 1'b1);

        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < 1500; i++) begin
                int  a;
                bit  v;
                bit  rr;
                v  = ($urandom_range(0, 3) != 0);
                a  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023))
                                                : 4 * int'($urandom_range(0, 255));
                rr = (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                cycle(v, a, rr);
            end
        end
        idle(12, 1'b1);

`ifdef ROM_STATS_EN
        check_eq("stat_fetches[0]", 64'(sf_a), 64'(acc_cnt[0]));
        check_eq("stat_errors[0]", 64'(se_a), 64'(err_cnt[0]));
        check_eq("stat_fetches[1]", 64'(sf_b), 64'(acc_cnt[1]));
        check_eq("stat_errors[1]", 64'(se_b), 64'(err_cnt[1]));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
